// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a 4x1 single-bit mux datapath.
// Grants one of four requesters at a time, drives the mux select and
// registers the selected data bit with a valid strobe. A per-grant hold
// limit bounds how long one requester can keep the output while others wait.
module mux_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       dout,
    output logic       dout_vld,
    output logic       busy
);

    localparam int unsigned HW = $clog2(HOLD_MAX + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e         state_q;
    logic [3:0]     gnt_q;
    logic [1:0]     sel_q;
    logic [1:0]     last_q;
    logic [HW-1:0]  hold_q;
    logic           dout_q;
    logic           vld_q;

    logic [3:0]     search_mask;
    logic [1:0]     search_start;
    logic [1:0]     search_idx;
    logic           win_vld;
    logic [1:0]     win;
    logic           hold_at_max;
    logic           transfer;

    // Winner search: starts after the last grant and wraps. While granting,
    // the current owner is masked out so it can only be kept by the explicit
    // "no other requester" path, i.e. it is effectively searched last.
    always_comb begin
        search_start = last_q + 2'd1;
        search_mask  = (state_q == GRANT) ? (req & ~(4'b0001 << last_q)) : req;
        search_idx   = '0;
        win_vld      = 1'b0;
        win          = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            search_idx = search_start + 2'(k);
            if (!win_vld && search_mask[search_idx]) begin
                win_vld = 1'b1;
                win     = search_idx;
            end
        end
    end

    assign hold_at_max = (hold_q == HW'(HOLD_MAX));
    assign transfer    = gnt_q[sel_q] & req[sel_q];

    // Arbitration FSM with registered grant, select and data outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= 2'd3;
            hold_q  <= '0;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    vld_q <= 1'b0;
                    if (win_vld) begin
                        state_q <= GRANT;
                        gnt_q   <= 4'b0001 << win;
                        sel_q   <= win;
                        last_q  <= win;
                        hold_q  <= HW'(1);
                    end
                end
                GRANT: begin
                    if (transfer) begin
                        dout_q <= din[sel_q];
                        vld_q  <= 1'b1;
                    end else begin
                        vld_q  <= 1'b0;
                    end

                    if (!req[sel_q]) begin
                        if (win_vld) begin
                            gnt_q  <= 4'b0001 << win;
                            sel_q  <= win;
                            last_q <= win;
                            hold_q <= HW'(1);
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else if (hold_at_max) begin
                        if (win_vld) begin
                            gnt_q  <= 4'b0001 << win;
                            sel_q  <= win;
                            last_q <= win;
                        end
                        hold_q <= HW'(1);
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign busy     = |gnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed testbench for mux_rr_arbiter with hand-computed expectations.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       dout;
    logic       dout_vld;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mux_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .din      (din),
        .gnt      (gnt),
        .sel      (sel),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        logic       exp_dout;
        int unsigned cur;

        rst_n = 1'b0;
        req   = '0;
        din   = '0;

        // 1: reset with all requests asserted, then first grant to requester 0
        req = 4'hF;
        step();
        step();
        check("t1_rst_gnt",  32'(gnt), 32'h0);
        check("t1_rst_sel",  32'(sel), 32'h0);
        check("t1_rst_vld",  32'(dout_vld), 32'h0);
        check("t1_rst_busy", 32'(busy), 32'h0);
        check("t1_rst_dout", 32'(dout), 32'h0);
        rst_n = 1'b1;
        step();
        check("t1_first_gnt", 32'(gnt), 32'h1);
        check("t1_first_busy", 32'(busy), 32'h1);

        // 2: single requester 2, three transfers 1,0,1, then release
        do_reset();
        req = 4'b0100;
        step();
        check("t2_gnt", 32'(gnt), 32'h4);
        check("t2_sel", 32'(sel), 32'h2);
        check("t2_vld0", 32'(dout_vld), 32'h0);
        din = 4'b0100; step();
        check("t2_dout_a", 32'(dout), 32'h1);
        check("t2_vld_a",  32'(dout_vld), 32'h1);
        din = 4'b1011; step();
        check("t2_dout_b", 32'(dout), 32'h0);
        check("t2_vld_b",  32'(dout_vld), 32'h1);
        din = 4'b0100; step();
        check("t2_dout_c", 32'(dout), 32'h1);
        check("t2_vld_c",  32'(dout_vld), 32'h1);
        check("t2_gnt_c",  32'(gnt), 32'h4);
        req = 4'b0000; din = 4'b0000; step();
        check("t2_rel_gnt",  32'(gnt), 32'h0);
        check("t2_rel_busy", 32'(busy), 32'h0);
        check("t2_rel_vld",  32'(dout_vld), 32'h0);
        check("t2_rel_sel",  32'(sel), 32'h2);
        check("t2_rel_dout", 32'(dout), 32'h1);
        step();
        check("t2_idle_vld", 32'(dout_vld), 32'h0);

        // 3: all requesting, each owner keeps exactly 8 cycles, order 0,1,2,3,0
        do_reset();
        req = 4'hF;
        step();
        check("t3_first_gnt", 32'(gnt), 32'h1);
        for (int unsigned k = 0; k < 39; k++) begin
            cur      = (k / 8) % 4;
            din      = 4'($urandom_range(0, 15));
            exp_dout = din[cur[1:0]];
            exp_gnt  = 4'b0001 << (((k + 1) / 8) % 4);
            step();
            check($sformatf("t3_gnt_%0d", k), 32'(gnt), 32'(exp_gnt));
            check($sformatf("t3_vld_%0d", k), 32'(dout_vld), 32'h1);
            check($sformatf("t3_dout_%0d", k), 32'(dout), 32'(exp_dout));
        end

        // 4: lone requester 0 keeps the grant across hold wrap, no vld gap
        do_reset();
        req = 4'b0001;
        step();
        check("t4_first_gnt", 32'(gnt), 32'h1);
        for (int unsigned k = 0; k < 20; k++) begin
            din      = (k % 2 == 0) ? 4'b0001 : 4'b1110;
            exp_dout = (k % 2 == 0);
            step();
            check($sformatf("t4_gnt_%0d", k), 32'(gnt), 32'h1);
            check($sformatf("t4_vld_%0d", k), 32'(dout_vld), 32'h1);
            check($sformatf("t4_dout_%0d", k), 32'(dout), 32'(exp_dout));
        end

        // 5: req 0 drops after 3 grant cycles, requester 1 takes over same edge
        do_reset();
        req = 4'b0011;
        step();
        check("t5_gnt1", 32'(gnt), 32'h1);
        step();
        check("t5_gnt2", 32'(gnt), 32'h1);
        step();
        check("t5_gnt3", 32'(gnt), 32'h1);
        req = 4'b0010;
        step();
        check("t5_sw_gnt",  32'(gnt), 32'h2);
        check("t5_sw_sel",  32'(sel), 32'h1);
        check("t5_sw_busy", 32'(busy), 32'h1);

        // 6: reset mid-grant, then requester 2 wins over 3 from fresh pointer
        do_reset();
        req = 4'b0100;
        din = 4'hF;
        step();
        check("t6_gnt", 32'(gnt), 32'h4);
        step();
        check("t6_vld_pre", 32'(dout_vld), 32'h1);
        check("t6_dout_pre", 32'(dout), 32'h1);
        rst_n = 1'b0;
        step();
        check("t6_rst_gnt",  32'(gnt), 32'h0);
        check("t6_rst_sel",  32'(sel), 32'h0);
        check("t6_rst_dout", 32'(dout), 32'h0);
        check("t6_rst_vld",  32'(dout_vld), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        req   = 4'b1100;
        step();
        check("t6_after_gnt", 32'(gnt), 32'h4);
        check("t6_after_sel", 32'(sel), 32'h2);

        // 7: owner 0 drops while 1 and 3 rise together; 1 is first after 0
        do_reset();
        req = 4'b0001;
        step();
        check("t7_gnt0", 32'(gnt), 32'h1);
        req = 4'b1010;
        step();
        check("t7_gnt1", 32'(gnt), 32'h2);
        req = 4'b1000;
        step();
        check("t7_gnt3", 32'(gnt), 32'h8);
        check("t7_sel3", 32'(sel), 32'h3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
